// File: rtl/reg_writeback_unit.sv
// Write-side buffer for the 32x32 register file: accepts ALU/load results,
// queues them in order and drains one per cycle onto A3/WD3/WE3.
module reg_writeback_unit #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_rd,
   input  logic [XLEN-1:0]          alu_data,
   output logic                     alu_ready,
   input  logic                     mem_valid,
   input  logic [4:0]               mem_rd,
   input  logic [XLEN-1:0]          mem_data,
   output logic                     mem_ready,
   input  logic                     wb_hold,
   output logic [4:0]               A3,
   output logic [XLEN-1:0]          WD3,
   output logic                     WE3,
   input  logic [4:0]               byp_rs,
   output logic                     byp_hit,
   output logic [XLEN-1:0]          byp_data,
   output logic [31:0]              pending,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [4:0]      rd_q   [DEPTH];
   logic [4:0]      rd_d   [DEPTH];
   logic [XLEN-1:0] data_q [DEPTH];
   logic [XLEN-1:0] data_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic            full, empty;
   logic            push_mem, push_alu, push, pop;
   logic [4:0]      push_rd;
   logic [XLEN-1:0] push_data;
   logic [PW-1:0]   idx;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Loads are older in program order, so they win the single push slot.
   assign mem_ready = !full;
   assign alu_ready = !full && !mem_valid;
   assign push_mem  = mem_valid && mem_ready;
   assign push_alu  = alu_valid && alu_ready;
   assign push      = push_mem || push_alu;
   assign push_rd   = push_mem ? mem_rd : alu_rd;
   assign push_data = push_mem ? mem_data : alu_data;
   assign pop       = !empty && !wb_hold;

   assign A3    = pop ? rd_q[rd_ptr_q] : 5'd0;
   assign WD3   = pop ? data_q[rd_ptr_q] : '0;
   assign WE3   = pop && (rd_q[rd_ptr_q] != 5'd0);
   assign count = count_q;

   always_comb begin
      rd_d     = rd_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         rd_d[wr_ptr_q]   = push_rd;
         data_d[wr_ptr_q] = push_data;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Walk oldest to youngest so the last match (youngest) wins the bypass.
   always_comb begin
      pending  = '0;
      byp_hit  = 1'b0;
      byp_data = '0;
      idx      = rd_ptr_q;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_q + PW'(k);
         if (CW'(k) < count_q) begin
            pending[rd_q[idx]] = 1'b1;
            if ((byp_rs != 5'd0) && (rd_q[idx] == byp_rs)) begin
               byp_hit  = 1'b1;
               byp_data = data_q[idx];
            end
         end
      end
      pending[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= 5'd0;
            data_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_q     <= rd_d;
         data_q   <= data_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit against a queue-based model of
// the in-order write buffer.
module tb_reg_writeback_unit;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid, mem_valid, wb_hold;
   logic [4:0]      alu_rd, mem_rd, byp_rs;
   logic [XLEN-1:0] alu_data, mem_data;
   logic            alu_ready, mem_ready, WE3, byp_hit;
   logic [4:0]      A3;
   logic [XLEN-1:0] WD3, byp_data;
   logic [31:0]     pending;
   logic [2:0]      count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   reg_writeback_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .wb_hold(wb_hold), .A3(A3), .WD3(WD3), .WE3(WE3),
      .byp_rs(byp_rs), .byp_hit(byp_hit), .byp_data(byp_data),
      .pending(pending), .count(count)
   );

   // One clock cycle: apply inputs just after an edge, compare every output
   // with the model mid-cycle, then advance the model at the next edge.
   task automatic run_cycle(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                            input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                            input logic hold, input logic [4:0] brs);
      logic        full, e_we, e_hit;
      logic [4:0]  e_a3;
      logic [31:0] e_wd, e_bd, e_pend;
      alu_valid = av; alu_rd = ard; alu_data = adat;
      mem_valid = mv; mem_rd = mrd; mem_data = mdat;
      wb_hold = hold; byp_rs = brs;
      #4;
      full = (q.size() == DEPTH);
      e_we = 0; e_a3 = 0; e_wd = 0;
      if (q.size() > 0 && !hold) begin
         e_a3 = q[0].rd; e_wd = q[0].data; e_we = (q[0].rd != 0);
      end
      e_pend = 0; e_hit = 0; e_bd = 0;
      foreach (q[i]) begin
         e_pend[q[i].rd] = 1'b1;
         if (brs != 0 && q[i].rd == brs) begin e_hit = 1; e_bd = q[i].data; end
      end
      e_pend[0] = 1'b0;
      total++;
      if (mem_ready !== !full) begin bad++; $display("FAIL mem_ready got=%b want=%b", mem_ready, !full); end
      total++;
      if (alu_ready !== (!full && !mv)) begin bad++; $display("FAIL alu_ready got=%b want=%b", alu_ready, !full && !mv); end
      total++;
      if ({WE3, A3, WD3} !== {e_we, e_a3, e_wd}) begin
         bad++; $display("FAIL write_port got we=%b a3=%0d wd=%h want we=%b a3=%0d wd=%h", WE3, A3, WD3, e_we, e_a3, e_wd);
      end
      total++;
      if (pending !== e_pend) begin bad++; $display("FAIL pending got=%h want=%h", pending, e_pend); end
      total++;
      if ({byp_hit, byp_data} !== {e_hit, e_bd}) begin
         bad++; $display("FAIL bypass rs=%0d got hit=%b data=%h want hit=%b data=%h", brs, byp_hit, byp_data, e_hit, e_bd);
      end
      total++;
      if (count !== 3'(q.size())) begin bad++; $display("FAIL count got=%0d want=%0d", count, q.size()); end
      @(posedge clk);
      if (q.size() > 0 && !hold) void'(q.pop_front());
      if (mv && !full) q.push_back('{mrd, mdat});
      else if (av && !full) q.push_back('{ard, adat});
      #1;
   endtask

   task automatic idle(input logic hold, input logic [4:0] brs);
      run_cycle(0, 0, 0, 0, 0, 0, hold, brs);
   endtask

   task automatic test_reset;
      rst = 0;
      alu_valid = 0; mem_valid = 0; wb_hold = 0; byp_rs = 0;
      alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
      #12;
      total++;
      if ({WE3, A3, WD3, count, pending, byp_hit, byp_data} !== '0) begin
         bad++; $display("FAIL reset_outputs got we=%b a3=%0d wd=%h cnt=%0d pend=%h hit=%b", WE3, A3, WD3, count, pending, byp_hit);
      end
      rst = 1;
      @(posedge clk); #1;
      total++;
      if ({alu_ready, mem_ready} !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b want=11", {alu_ready, mem_ready}); end
      q.delete();
   endtask

   task automatic test_single;
      run_cycle(1, 5, 32'h5, 0, 0, 0, 0, 5);
      total++;
      if ({WE3, A3, WD3, pending[5]} !== {1'b1, 5'd5, 32'h5, 1'b1}) begin
         bad++; $display("FAIL single_write got we=%b a3=%0d wd=%h p5=%b want 1/5/5/1", WE3, A3, WD3, pending[5]);
      end
      idle(0, 5);
      total++;
      if ({count, pending[5], WE3} !== 5'b0) begin
         bad++; $display("FAIL single_drained got cnt=%0d p5=%b we=%b want 0/0/0", count, pending[5], WE3);
      end
   endtask

   task automatic test_priority;
      run_cycle(1, 7, 32'h9, 1, 6, 32'h4, 0, 0);
      total++;
      if ({WE3, A3, WD3} !== {1'b1, 5'd6, 32'h4}) begin
         bad++; $display("FAIL prio_first got a3=%0d wd=%h want 6/4", A3, WD3);
      end
      run_cycle(1, 7, 32'h9, 0, 0, 0, 0, 0);
      total++;
      if ({WE3, A3, WD3} !== {1'b1, 5'd7, 32'h9}) begin
         bad++; $display("FAIL prio_second got a3=%0d wd=%h want 7/9", A3, WD3);
      end
      idle(0, 0);
   endtask

   task automatic test_full_hold;
      for (int i = 0; i < 5; i++) run_cycle(1, 5'(10 + i), 32'(100 + i), 0, 0, 0, 1, 0);
      total++;
      if ({count, alu_ready, pending[13:10], pending[14]} !== {3'd4, 1'b0, 4'hF, 1'b0}) begin
         bad++; $display("FAIL full_hold got cnt=%0d ar=%b pend=%h want 4/0/00003c00", count, alu_ready, pending);
      end
      for (int i = 0; i < 4; i++) begin
         wb_hold = 0; #1;
         total++;
         if ({WE3, A3, WD3} !== {1'b1, 5'(10 + i), 32'(100 + i)}) begin
            bad++; $display("FAIL drain_order[%0d] got a3=%0d wd=%h want %0d/%0d", i, A3, WD3, 10 + i, 100 + i);
         end
         #(-1 + 1); run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
      end
      total++;
      if (count !== 0) begin bad++; $display("FAIL drain_empty got cnt=%0d want 0", count); end
   endtask

   task automatic test_bypass;
      run_cycle(1, 9, 32'h11, 0, 0, 0, 1, 0);
      run_cycle(1, 9, 32'h22, 0, 0, 0, 1, 9);
      idle(1, 9);
      total++;
      if ({byp_hit, byp_data} !== {1'b1, 32'h22}) begin
         bad++; $display("FAIL bypass_youngest got hit=%b data=%h want 1/22", byp_hit, byp_data);
      end
      idle(1, 0);
      idle(1, 12);
      idle(0, 9);
      idle(0, 9);
      idle(0, 9);
   endtask

   task automatic test_rd_zero;
      run_cycle(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      total++;
      if ({WE3, A3, WD3, count, pending, byp_hit} !== {1'b0, 5'd0, 32'hDEADBEEF, 3'd1, 32'h0, 1'b0}) begin
         bad++; $display("FAIL rd_zero got we=%b a3=%0d wd=%h cnt=%0d pend=%h hit=%b", WE3, A3, WD3, count, pending, byp_hit);
      end
      idle(0, 0);
   endtask

   task automatic test_random;
      for (int n = 0; n < 400; n++) begin
         run_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
      end
      for (int n = 0; n < DEPTH + 1; n++) idle(0, 0);
   endtask

   task automatic test_async_reset;
      for (int i = 0; i < 4; i++) run_cycle(1, 5'(20 + i), 32'(200 + i), 0, 0, 0, 1, 0);
      idle(0, 0);
      wb_hold = 0; alu_valid = 0; mem_valid = 0; byp_rs = 21;
      #1;
      total++;
      if ({WE3, count} !== {1'b1, 3'd3}) begin bad++; $display("FAIL pre_reset got we=%b cnt=%0d want 1/3", WE3, count); end
      rst = 0;
      #1;
      total++;
      if ({WE3, A3, WD3, count, pending, byp_hit, byp_data} !== '0) begin
         bad++; $display("FAIL async_reset got we=%b a3=%0d wd=%h cnt=%0d pend=%h hit=%b", WE3, A3, WD3, count, pending, byp_hit);
      end
      q.delete();
      @(posedge clk); #3;
      rst = 1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) idle(0, 21);
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_full_hold();
      test_bypass();
      test_rd_zero();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
